// File: rtl/copy_engine.sv
// copy_engine: single-beat AXI4 memory-to-memory word copier.
// Ports: CONFIG_* command, M_AXI_* master, STATUS_* (busy/done/err).
module copy_engine #(
  parameter int ID_W   = 12,
  parameter int AXI_ID = 0
) (
  input  logic            ACLK,
  input  logic            ARESETN,
  input  logic            CONFIG_VALID,
  output logic            CONFIG_READY,
  input  logic [31:0]     CONFIG_CMD,
  input  logic [31:0]     CONFIG_SRC,
  input  logic [31:0]     CONFIG_DEST,
  input  logic [31:0]     CONFIG_LEN,
  output logic [ID_W-1:0] M_AXI_ARID,
  output logic [31:0]     M_AXI_ARADDR,
  output logic [3:0]      M_AXI_ARLEN,
  output logic [2:0]      M_AXI_ARSIZE,
  output logic [1:0]      M_AXI_ARBURST,
  output logic            M_AXI_ARVALID,
  input  logic            M_AXI_ARREADY,
  input  logic [31:0]     M_AXI_RDATA,
  input  logic [1:0]      M_AXI_RRESP,
  input  logic            M_AXI_RLAST,
  input  logic            M_AXI_RVALID,
  output logic            M_AXI_RREADY,
  output logic [ID_W-1:0] M_AXI_AWID,
  output logic [31:0]     M_AXI_AWADDR,
  output logic [3:0]      M_AXI_AWLEN,
  output logic [2:0]      M_AXI_AWSIZE,
  output logic [1:0]      M_AXI_AWBURST,
  output logic            M_AXI_AWVALID,
  input  logic            M_AXI_AWREADY,
  output logic [31:0]     M_AXI_WDATA,
  output logic [3:0]      M_AXI_WSTRB,
  output logic            M_AXI_WLAST,
  output logic            M_AXI_WVALID,
  input  logic            M_AXI_WREADY,
  input  logic [1:0]      M_AXI_BRESP,
  input  logic            M_AXI_BVALID,
  output logic            M_AXI_BREADY,
  output logic            STATUS_BUSY,
  output logic            STATUS_DONE,
  output logic            STATUS_ERR
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RADDR,
    S_RDATA,
    S_WRITE,
    S_WRESP
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_raddr;
  logic [31:0] r_waddr;
  logic [31:0] r_data;
  logic [29:0] r_words;
  logic [29:0] r_cnt;
  logic        r_aw_done;
  logic        r_w_done;
  logic        r_done;
  logic        r_err;

  logic        w_accept;
  logic        w_go;
  logic [29:0] w_words;
  logic [29:0] w_cnt_nxt;
  logic        w_last;
  logic        w_aw_hs;
  logic        w_w_hs;
  logic        w_wr_done;
  logic        w_unused;

  assign w_unused = &{1'b0, CONFIG_CMD[31:1], CONFIG_SRC[1:0],
                      CONFIG_DEST[1:0], CONFIG_LEN[1:0], M_AXI_RLAST};

  assign w_words   = CONFIG_LEN[31:2];
  assign w_accept  = CONFIG_VALID && (r_state == S_IDLE);
  assign w_go      = w_accept && CONFIG_CMD[0] && (w_words != 30'd0);
  assign w_cnt_nxt = r_cnt + 30'd1;
  assign w_last    = (w_cnt_nxt == r_words);

  assign w_aw_hs   = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_w_hs    = M_AXI_WVALID && M_AXI_WREADY;
  // Address and data channels may complete in either order.
  assign w_wr_done = (r_aw_done || w_aw_hs) && (r_w_done || w_w_hs);

  assign CONFIG_READY  = (r_state == S_IDLE);
  assign STATUS_BUSY   = (r_state != S_IDLE);
  assign STATUS_DONE   = r_done;
  assign STATUS_ERR    = r_err;

  assign M_AXI_ARID    = ID_W'(AXI_ID);
  assign M_AXI_AWID    = ID_W'(AXI_ID);
  assign M_AXI_ARLEN   = 4'd0;
  assign M_AXI_AWLEN   = 4'd0;
  assign M_AXI_ARSIZE  = 3'b010;
  assign M_AXI_AWSIZE  = 3'b010;
  assign M_AXI_ARBURST = 2'b01;
  assign M_AXI_AWBURST = 2'b01;
  assign M_AXI_WSTRB   = 4'hF;
  assign M_AXI_WLAST   = 1'b1;

  assign M_AXI_ARADDR  = r_raddr;
  assign M_AXI_AWADDR  = r_waddr;
  assign M_AXI_WDATA   = r_data;
  assign M_AXI_ARVALID = (r_state == S_RADDR);
  assign M_AXI_RREADY  = (r_state == S_RDATA);
  assign M_AXI_AWVALID = (r_state == S_WRITE) && !r_aw_done;
  assign M_AXI_WVALID  = (r_state == S_WRITE) && !r_w_done;
  assign M_AXI_BREADY  = (r_state == S_WRESP);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_go) w_next = S_RADDR;
      end
      S_RADDR: begin
        if (M_AXI_ARREADY) w_next = S_RDATA;
      end
      S_RDATA: begin
        if (M_AXI_RVALID) begin
          if (M_AXI_RRESP != 2'b00) w_next = S_IDLE;
          else                      w_next = S_WRITE;
        end
      end
      S_WRITE: begin
        if (w_wr_done) w_next = S_WRESP;
      end
      S_WRESP: begin
        if (M_AXI_BVALID) begin
          if (M_AXI_BRESP != 2'b00) w_next = S_IDLE;
          else if (w_last)          w_next = S_IDLE;
          else                      w_next = S_RADDR;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_raddr   <= 32'd0;
      r_waddr   <= 32'd0;
      r_data    <= 32'd0;
      r_words   <= 30'd0;
      r_cnt     <= 30'd0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_raddr <= {CONFIG_SRC[31:2], 2'b00};
            r_waddr <= {CONFIG_DEST[31:2], 2'b00};
            r_words <= w_words;
            r_cnt   <= 30'd0;
            r_err   <= 1'b0;
            // No-op and zero-length commands finish immediately.
            if (!w_go) r_done <= 1'b1;
          end
        end
        S_RADDR: begin
        end
        S_RDATA: begin
          if (M_AXI_RVALID) begin
            r_data    <= M_AXI_RDATA;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            if (M_AXI_RRESP != 2'b00) begin
              r_err  <= 1'b1;
              r_done <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          if (w_aw_hs) r_aw_done <= 1'b1;
          if (w_w_hs)  r_w_done  <= 1'b1;
        end
        S_WRESP: begin
          if (M_AXI_BVALID) begin
            if (M_AXI_BRESP != 2'b00) begin
              r_err  <= 1'b1;
              r_done <= 1'b1;
            end else begin
              r_cnt   <= w_cnt_nxt;
              r_raddr <= r_raddr + 32'd4;
              r_waddr <= r_waddr + 32'd4;
              if (w_last) r_done <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_copy_engine.sv
// tb_copy_engine: directed vector bench for copy_engine with
// a behavioural single-beat AXI slave and traffic logging.
module tb_copy_engine;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic        CONFIG_VALID;
  logic        CONFIG_READY;
  logic [31:0] CONFIG_CMD, CONFIG_SRC, CONFIG_DEST, CONFIG_LEN;
  logic [11:0] M_AXI_ARID, M_AXI_AWID;
  logic [31:0] M_AXI_ARADDR, M_AXI_AWADDR;
  logic [3:0]  M_AXI_ARLEN, M_AXI_AWLEN;
  logic [2:0]  M_AXI_ARSIZE, M_AXI_AWSIZE;
  logic [1:0]  M_AXI_ARBURST, M_AXI_AWBURST;
  logic        M_AXI_ARVALID, M_AXI_ARREADY;
  logic [31:0] M_AXI_RDATA;
  logic [1:0]  M_AXI_RRESP;
  logic        M_AXI_RLAST, M_AXI_RVALID, M_AXI_RREADY;
  logic        M_AXI_AWVALID, M_AXI_AWREADY;
  logic [31:0] M_AXI_WDATA;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_WLAST, M_AXI_WVALID, M_AXI_WREADY;
  logic [1:0]  M_AXI_BRESP;
  logic        M_AXI_BVALID, M_AXI_BREADY;
  logic        STATUS_BUSY, STATUS_DONE, STATUS_ERR;

  copy_engine #(.ID_W(12), .AXI_ID(0)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .CONFIG_VALID(CONFIG_VALID), .CONFIG_READY(CONFIG_READY),
    .CONFIG_CMD(CONFIG_CMD), .CONFIG_SRC(CONFIG_SRC),
    .CONFIG_DEST(CONFIG_DEST), .CONFIG_LEN(CONFIG_LEN),
    .M_AXI_ARID(M_AXI_ARID), .M_AXI_ARADDR(M_AXI_ARADDR),
    .M_AXI_ARLEN(M_AXI_ARLEN), .M_AXI_ARSIZE(M_AXI_ARSIZE),
    .M_AXI_ARBURST(M_AXI_ARBURST), .M_AXI_ARVALID(M_AXI_ARVALID),
    .M_AXI_ARREADY(M_AXI_ARREADY), .M_AXI_RDATA(M_AXI_RDATA),
    .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RLAST(M_AXI_RLAST),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY),
    .M_AXI_AWID(M_AXI_AWID), .M_AXI_AWADDR(M_AXI_AWADDR),
    .M_AXI_AWLEN(M_AXI_AWLEN), .M_AXI_AWSIZE(M_AXI_AWSIZE),
    .M_AXI_AWBURST(M_AXI_AWBURST), .M_AXI_AWVALID(M_AXI_AWVALID),
    .M_AXI_AWREADY(M_AXI_AWREADY), .M_AXI_WDATA(M_AXI_WDATA),
    .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WLAST(M_AXI_WLAST),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID),
    .M_AXI_BREADY(M_AXI_BREADY),
    .STATUS_BUSY(STATUS_BUSY), .STATUS_DONE(STATUS_DONE),
    .STATUS_ERR(STATUS_ERR)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [31:0] cmd, src, dst, len;
    int          aw_dly, w_dly, rerr, berr;
    int          exp_rd, exp_wr;
    logic        exp_err;
  } vec_t;

  int n_chk = 0;
  int n_pass = 0;

  logic [31:0] ar_q[$];
  logic [31:0] aw_q[$];
  logic [31:0] w_q[$];
  logic [31:0] last_ar;
  int aw_dly, w_dly, rerr, berr;
  int aw_wait, w_wait, r_idx, b_idx;
  int done_cnt, viol;
  bit aw_seen, w_seen, busy_seen;

  function automatic logic [31:0] fdat(logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic clear_logs();
    ar_q.delete(); aw_q.delete(); w_q.delete();
    aw_wait = 0; w_wait = 0; r_idx = 0; b_idx = 0;
    done_cnt = 0; viol = 0;
    aw_seen = 0; w_seen = 0; busy_seen = 0;
  endtask

  // Slave responder and protocol monitor, acting on falling edges.
  initial begin
    M_AXI_ARREADY = 1'b1;
    M_AXI_RVALID = 0; M_AXI_RDATA = 0; M_AXI_RRESP = 0; M_AXI_RLAST = 1;
    M_AXI_AWREADY = 0; M_AXI_WREADY = 0;
    M_AXI_BVALID = 0; M_AXI_BRESP = 0;
    last_ar = 0;
    forever begin
      @(negedge ACLK);
      if (M_AXI_ARVALID) begin
        ar_q.push_back(M_AXI_ARADDR);
        last_ar = M_AXI_ARADDR;
      end
      if (M_AXI_RREADY) begin
        M_AXI_RVALID = 1'b1;
        M_AXI_RDATA  = fdat(last_ar);
        M_AXI_RRESP  = (r_idx == rerr) ? 2'b10 : 2'b00;
        r_idx++;
      end else begin
        M_AXI_RVALID = 1'b0;
        M_AXI_RDATA  = 32'd0;
        M_AXI_RRESP  = 2'b00;
      end
      if (M_AXI_AWVALID) begin
        if (aw_seen) viol++;
        if (aw_wait >= aw_dly) begin
          M_AXI_AWREADY = 1'b1;
          aw_q.push_back(M_AXI_AWADDR);
          aw_seen = 1;
        end else begin
          M_AXI_AWREADY = 1'b0;
          aw_wait++;
        end
      end else begin
        M_AXI_AWREADY = 1'b0;
        aw_wait = 0;
      end
      if (M_AXI_WVALID) begin
        if (w_seen) viol++;
        if (w_wait >= w_dly) begin
          M_AXI_WREADY = 1'b1;
          w_q.push_back(M_AXI_WDATA);
          w_seen = 1;
        end else begin
          M_AXI_WREADY = 1'b0;
          w_wait++;
        end
      end else begin
        M_AXI_WREADY = 1'b0;
        w_wait = 0;
      end
      if (M_AXI_BREADY) begin
        M_AXI_BVALID = 1'b1;
        M_AXI_BRESP  = (b_idx == berr) ? 2'b10 : 2'b00;
        b_idx++;
        aw_seen = 0;
        w_seen = 0;
      end else begin
        M_AXI_BVALID = 1'b0;
        M_AXI_BRESP  = 2'b00;
      end
      if ((M_AXI_ARVALID || M_AXI_RREADY) &&
          (M_AXI_AWVALID || M_AXI_WVALID || M_AXI_BREADY)) viol++;
      if (STATUS_DONE) begin
        done_cnt++;
        if (STATUS_BUSY) viol++;
      end
      if (STATUS_BUSY || !CONFIG_READY) busy_seen = 1;
    end
  end

  task automatic tick();
    @(negedge ACLK);
    #1;
  endtask

  task automatic run_vec(vec_t v, int id);
    logic [31:0] sb, db;
    clear_logs();
    aw_dly = v.aw_dly; w_dly = v.w_dly;
    rerr = v.rerr; berr = v.berr;
    CONFIG_VALID = 1'b1;
    CONFIG_CMD = v.cmd; CONFIG_SRC = v.src;
    CONFIG_DEST = v.dst; CONFIG_LEN = v.len;
    chk($sformatf("v%0d_cfg_ready", id), CONFIG_READY, 1);
    tick();
    CONFIG_VALID = 1'b0;
    CONFIG_CMD = 32'h1; CONFIG_SRC = 32'hDEAD_BEE0;
    CONFIG_DEST = 32'hCAFE_0000; CONFIG_LEN = 32'h40;
    if (v.exp_rd == 0)
      chk($sformatf("v%0d_done_k1", id), STATUS_DONE, 1);
    else
      chk($sformatf("v%0d_arvalid_k1", id), M_AXI_ARVALID, 1);
    for (int c = 0; c < 300 && done_cnt == 0; c++) tick();
    repeat (4) tick();
    chk($sformatf("v%0d_done_cnt", id), done_cnt, 1);
    chk($sformatf("v%0d_reads", id), ar_q.size(), v.exp_rd);
    chk($sformatf("v%0d_aw", id), aw_q.size(), v.exp_wr);
    chk($sformatf("v%0d_w", id), w_q.size(), v.exp_wr);
    chk($sformatf("v%0d_err", id), STATUS_ERR, v.exp_err);
    chk($sformatf("v%0d_viol", id), viol, 0);
    chk($sformatf("v%0d_busy_seen", id), busy_seen, v.exp_rd != 0);
    chk($sformatf("v%0d_idle", id), CONFIG_READY, 1);
    sb = v.src & 32'hFFFF_FFFC;
    db = v.dst & 32'hFFFF_FFFC;
    for (int j = 0; j < ar_q.size(); j++)
      chk($sformatf("v%0d_araddr%0d", id, j), ar_q[j], sb + 32'(4 * j));
    for (int j = 0; j < aw_q.size(); j++)
      chk($sformatf("v%0d_awaddr%0d", id, j), aw_q[j], db + 32'(4 * j));
    for (int j = 0; j < w_q.size(); j++)
      chk($sformatf("v%0d_wdata%0d", id, j), w_q[j],
          fdat(sb + 32'(4 * j)));
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{32'h1, 32'h1000, 32'h2000, 32'd12, 0, 0, -1, -1, 3, 3, 1'b0};
    vecs[1] = '{32'h0, 32'h1000, 32'h2000, 32'd64, 0, 0, -1, -1, 0, 0, 1'b0};
    vecs[2] = '{32'h1, 32'h3000, 32'h3800, 32'd8, 0, 3, -1, -1, 2, 2, 1'b0};
    vecs[3] = '{32'h1, 32'h3100, 32'h3900, 32'd8, 3, 0, -1, -1, 2, 2, 1'b0};
    vecs[4] = '{32'h1, 32'h4000, 32'h4800, 32'd8, 0, 0, 1, -1, 2, 1, 1'b1};
    vecs[5] = '{32'h1, 32'hFFFF_FFFC, 32'h5000, 32'd8, 0, 0, -1, -1, 2, 2, 1'b0};
    vecs[6] = '{32'h1, 32'h1000, 32'h2000, 32'd3, 0, 0, -1, -1, 0, 0, 1'b0};
    vecs[7] = '{32'hFFFF_FFFE, 32'h1000, 32'h2000, 32'd16, 0, 0, -1, -1, 0, 0, 1'b0};
    vecs[8] = '{32'h3, 32'h6003, 32'h6802, 32'd7, 1, 1, -1, -1, 1, 1, 1'b0};
    vecs[9] = '{32'h1, 32'h7000, 32'h7800, 32'd12, 0, 0, -1, 0, 1, 1, 1'b1};

    ARESETN = 1'b0;
    CONFIG_VALID = 0; CONFIG_CMD = 0; CONFIG_SRC = 0;
    CONFIG_DEST = 0; CONFIG_LEN = 0;
    aw_dly = 0; w_dly = 0; rerr = -1; berr = -1;
    clear_logs();
    tick(); tick();
    chk("rst_ready", CONFIG_READY, 1);
    chk("rst_busy", STATUS_BUSY, 0);
    chk("rst_done", STATUS_DONE, 0);
    chk("rst_err", STATUS_ERR, 0);
    chk("rst_valids", {M_AXI_ARVALID, M_AXI_AWVALID, M_AXI_WVALID,
                       M_AXI_RREADY, M_AXI_BREADY}, 0);
    chk("const_ar", {M_AXI_ARID, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST},
        {12'd0, 4'd0, 3'b010, 2'b01});
    chk("const_aw", {M_AXI_AWID, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST},
        {12'd0, 4'd0, 3'b010, 2'b01});
    chk("const_w", {M_AXI_WSTRB, M_AXI_WLAST}, 5'b11111);
    ARESETN = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Asynchronous reset while a write address is waiting.
    clear_logs();
    aw_dly = 10; w_dly = 10; rerr = -1; berr = -1;
    CONFIG_VALID = 1; CONFIG_CMD = 1;
    CONFIG_SRC = 32'h8000; CONFIG_DEST = 32'h8800; CONFIG_LEN = 32'd8;
    tick();
    CONFIG_VALID = 0;
    for (int c = 0; c < 50 && !M_AXI_AWVALID; c++) tick();
    chk("rs_awvalid_pre", M_AXI_AWVALID, 1);
    ARESETN = 1'b0;
    #1;
    chk("rs_valids", {M_AXI_ARVALID, M_AXI_AWVALID, M_AXI_WVALID,
                      M_AXI_RREADY, M_AXI_BREADY}, 0);
    chk("rs_busy", STATUS_BUSY, 0);
    chk("rs_ready", CONFIG_READY, 1);
    tick(); tick();
    clear_logs();
    aw_dly = 0; w_dly = 0;
    CONFIG_VALID = 1; CONFIG_CMD = 1;
    CONFIG_SRC = 32'h9000; CONFIG_DEST = 32'h9800; CONFIG_LEN = 32'd4;
    ARESETN = 1'b1;
    chk("rs_err", STATUS_ERR, 0);
    tick();
    CONFIG_VALID = 0;
    chk("rs_first_accept", M_AXI_ARVALID, 1);
    chk("rs_first_addr", M_AXI_ARADDR, 32'h9000);
    for (int c = 0; c < 100 && done_cnt == 0; c++) tick();
    repeat (3) tick();
    chk("rs_done_cnt", done_cnt, 1);
    chk("rs_reads", ar_q.size(), 1);
    chk("rs_writes", aw_q.size(), 1);
    if (aw_q.size() == 1) chk("rs_awaddr", aw_q[0], 32'h9800);
    if (w_q.size() == 1) chk("rs_wdata", w_q[0], fdat(32'h9000));
    chk("rs_viol", viol, 0);
    chk("rs_err_end", STATUS_ERR, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
